// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK_CODE         = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE           = 8'hE0;
  localparam int         PS2_DEFAULT_TIMEOUT    = 12000;
  localparam int         PS2_DEFAULT_FILTER_LEN = 4;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes both PS/2 lines and deglitches the clock; emits a one-cycle
// pulse on each filtered clock falling edge plus the synchronized data level.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive synchronized samples disagree with filt.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data = data_sync[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserializes 11-bit frames, checks parity/stop,
// and folds F0/E0 prefixes into flags on the following key event.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_DEFAULT_TIMEOUT,
  parameter int FILTER_LEN     = PS2_DEFAULT_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_extended,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall;
  logic          data;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic          break_pending;
  logic          ext_pending;
  logic [TW-1:0] to_cnt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data     (data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      parity_bit    <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      to_cnt        <= '0;
      scan_code     <= '0;
      key_valid     <= 1'b0;
      key_break     <= 1'b0;
      key_extended  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        // A fall always wins over a simultaneous timeout.
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data && odd_parity_ok(shift, parity_bit)) begin
              if (shift == PS2_BREAK_CODE) begin
                break_pending <= 1'b1;
              end else if (shift == PS2_EXT_CODE) begin
                ext_pending <= 1'b1;
              end else begin
                key_valid     <= 1'b1;
                scan_code     <= shift;
                key_break     <= break_pending;
                key_extended  <= ext_pending;
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
              end
            end else begin
              frame_err     <= 1'b1;
              break_pending <= 1'b0;
              ext_pending   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state         <= IDLE;
          to_cnt        <= '0;
          frame_err     <= 1'b1;
          break_pending <= 1'b0;
          ext_pending   <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: PS/2 frames driven at a 40 us bit period
// against a 12 MHz clock, key events checked through an expected queue.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int TIMEOUT = 12000;
  localparam int FLEN    = 4;
  localparam int HALF    = 240;   // 20 us at 12 MHz

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       key_valid;
  logic       key_break;
  logic       key_extended;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fall_cyc = 0;
  int kv_seen  = 0;
  int err_seen = 0;

  // Entry layout: {extended, break, scan_code}
  logic [9:0] exp_q[$];

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(FLEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .scan_code    (scan_code),
    .key_valid    (key_valid),
    .key_break    (key_break),
    .key_extended (key_extended),
    .frame_err    (frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (key_valid || frame_err)
      check("kv_err_exclusive", 32'(key_valid & frame_err), 32'd0);
    if (frame_err) err_seen++;
    if (key_valid) begin
      kv_seen++;
      check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_scan_code", 32'(scan_code), 32'(e[7:0]));
        check("sb_key_break", 32'(key_break), 32'(e[8]));
        check("sb_key_extended", 32'(key_extended), 32'(e[9]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic ps2_bit(input logic d);
    ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_parity);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic expect_key(input logic [7:0] code, input logic brk, input logic ext);
    exp_q.push_back({ext, brk, code});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int kv0;
    int e0;
    int delta;
    logic found;

    repeat (5) @(negedge clk);
    check("rst_scan_code", 32'(scan_code), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_break", 32'(key_break), 32'd0);
    check("rst_key_extended", 32'(key_extended), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Plain make code
    kv0 = kv_seen; e0 = err_seen;
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("t1_kv_count", 32'(kv_seen - kv0), 32'd1);
    check("t1_no_err", 32'(err_seen - e0), 32'd0);
    check("t1_hold_scan_code", 32'(scan_code), 32'h1C);

    // Break prefix, then plain repeat clears break
    kv0 = kv_seen;
    send_frame(PS2_BREAK_CODE, 1'b0);
    check("t2_no_kv_on_prefix", 32'(kv_seen - kv0), 32'd0);
    expect_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("t2_kv_count", 32'(kv_seen - kv0), 32'd1);
    check("t2_hold_key_break", 32'(key_break), 32'd1);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);

    // Extended break
    kv0 = kv_seen;
    send_frame(PS2_EXT_CODE, 1'b0);
    send_frame(PS2_BREAK_CODE, 1'b0);
    expect_key(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0);
    check("t3_kv_count", 32'(kv_seen - kv0), 32'd1);

    // Parity error drops the pending break
    kv0 = kv_seen; e0 = err_seen;
    send_frame(PS2_BREAK_CODE, 1'b0);
    send_frame(8'h1C, 1'b1);
    check("t4_err_count", 32'(err_seen - e0), 32'd1);
    check("t4_no_kv", 32'(kv_seen - kv0), 32'd0);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);

    // Timeout on a partial frame
    e0 = err_seen; kv0 = kv_seen;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    ps2_data = 1'b1;
    found = 1'b0;
    delta = 0;
    while (!found && (cyc - last_fall_cyc) < TIMEOUT + 50) begin
      @(negedge clk);
      if (frame_err) begin
        found = 1'b1;
        delta = cyc - last_fall_cyc;
      end
    end
    check("t5_timeout_seen", 32'(found), 32'd1);
    check("t5_timeout_not_early", 32'(delta >= TIMEOUT), 32'd1);
    check("t5_timeout_not_late", 32'(delta <= TIMEOUT + 10), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_err_count", 32'(err_seen - e0), 32'd1);
    check("t5_state_idle", 32'(dut.state), 32'(IDLE));
    expect_key(8'h45, 1'b0, 1'b0);
    send_frame(8'h45, 1'b0);
    check("t5_kv_count", 32'(kv_seen - kv0), 32'd1);

    // Glitches shorter than the filter length
    e0 = err_seen; kv0 = kv_seen;
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      repeat (FLEN - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (40) @(negedge clk);
    end
    check("t6_idle_after_glitch", 32'(dut.state), 32'(IDLE));
    ps2_bit(1'b0);                 // start of 0x16
    ps2_bit(1'b0); ps2_bit(1'b1);  // d0, d1
    repeat (60) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FLEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (60) @(negedge clk);
    check("t6_data_after_glitch", 32'(dut.state), 32'(DATA));
    check("t6_bitcnt_after_glitch", 32'(dut.bit_cnt), 32'd2);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);  // d2..d4
    // Reset while bit 5 is on the line, before its falling edge
    ps2_data = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_no_kv", 32'(key_valid), 32'd0);
    check("t6_rst_no_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_post_rst_no_kv", 32'(key_valid), 32'd0);
    check("t6_post_rst_no_err", 32'(frame_err), 32'd0);
    check("t6_post_rst_idle", 32'(dut.state), 32'(IDLE));
    ps2_data = 1'b1;
    repeat (300) @(negedge clk);
    check("t6_glitch_no_err", 32'(err_seen - e0), 32'd0);
    check("t6_glitch_no_kv", 32'(kv_seen - kv0), 32'd0);
    expect_key(8'h16, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0);
    check("t6_kv_count", 32'(kv_seen - kv0), 32'd1);

    // Totals
    repeat (20) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_kv_total", 32'(kv_seen), 32'd7);
    check("final_err_total", 32'(err_seen), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
